sram_zbt_controller: RTL and testbench
======================================

Name: sram_zbt_controller

Overview:
- Physical-side SRAM controller directly downstream of the SRAM arbiter. Consumes the arbiter's single request stream (addr_valid/ready, addr, data_in, write_mask) and drives a pipelined ZBT SRAM.
- Returns read data to the arbiter on sram_data_out/sram_data_out_valid.
- Runs entirely in the arbiter's SRAM clock domain. Clock forwarding to the device is handled at top level.

Parameters:
- ADDR_WIDTH, 18, word address width.
- DATA_WIDTH, 32, data width; mask width is DATA_WIDTH/8.
- DEV_LATENCY, 2, ZBT pipeline depth from address cycle to data cycle.
- INIT_CYCLES, 8, post-reset cycles before accepting requests.

Ports:
- clock  in  1  single clock (the arbiter's sram_clock).
- reset  in  1  asynchronous, active-low reset.
- sram_addr_valid  in  1  request valid from arbiter.
- sram_ready  out  1  controller can accept a request this cycle.
- sram_addr  in  ADDR_WIDTH  word address.
- sram_data_in  in  DATA_WIDTH  write data.
- sram_write_mask  in  4  byte enables; 0 means read, nonzero means write.
- sram_data_out  out  DATA_WIDTH  read data to arbiter.
- sram_data_out_valid  out  1  one-cycle pulse per completed read.
- zbt_a  out  ADDR_WIDTH  device address.
- zbt_ce_n  out  1  chip enable.
- zbt_we_n  out  1  write enable.
- zbt_bw_n  out  4  byte-write enables, active low.
- zbt_adv_ld_n  out  1  held 0 (load every cycle).
- zbt_oe_n  out  1  output enable.
- zbt_dq_out  out  DATA_WIDTH  write data to pad.
- zbt_dq_oe  out  1  pad tristate enable, 1 = drive.
- zbt_dq_in  in  DATA_WIDTH  data from pad.

Behaviour:
- Reset (reset=0, takes effect asynchronously):
  - Outputs: sram_ready=0, sram_data_out=0, sram_data_out_valid=0, zbt_ce_n=1, zbt_we_n=1, zbt_bw_n=4'hF, zbt_a=0, zbt_oe_n=1, zbt_dq_oe=0, zbt_dq_out=0, zbt_adv_ld_n=0.
  - All pipeline valid bits cleared; state=INIT.
- State machine: INIT -> RUN.
  - INIT: counter runs 0..INIT_CYCLES-1; sram_ready=0, pins idle.
  - RUN: entered the cycle after the counter reaches INIT_CYCLES-1. sram_ready=1 every cycle, zbt_oe_n=0. No back-pressure; ZBT needs no turnaround.
  - No other states.
- Accept:
  - A request is accepted in cycle C when sram_addr_valid && sram_ready.
  - Inputs with sram_addr_valid=0 are ignored.
- Stage 1 (cycle C+1), pins registered from the accepted request:
  - zbt_a=addr, zbt_ce_n=0.
  - zbt_we_n = (mask==0).
  - zbt_bw_n = ~mask for writes, 4'hF for reads.
  - No request in C: zbt_ce_n=1, zbt_we_n=1, zbt_bw_n=4'hF, zbt_a holds its value.
- Op tracking: a shift pipeline of {valid, is_write, data} tracks each op DEV_LATENCY cycles past the address cycle.
- Write data: in cycle C+1+DEV_LATENCY (C+3 default), zbt_dq_out=data and zbt_dq_oe=1 for exactly that cycle; otherwise zbt_dq_oe=0.
- Read data:
  - zbt_dq_in is registered at the end of cycle C+1+DEV_LATENCY.
  - sram_data_out is updated and sram_data_out_valid=1 in cycle C+2+DEV_LATENCY (C+4 default). Accept-to-valid latency is 4 cycles.
  - sram_data_out holds its last value when valid=0.
- Throughput: one op per cycle, any mix of reads and writes, in order. At most DEV_LATENCY+1 ops in flight.
- Back-to-back W then R: the write drive cycle and the read sample cycle are distinct, so no bus contention. dq_oe is never 1 in a read's sample cycle.
- Reset mid-operation: in-flight reads are dropped with no valid pulse; zbt_dq_oe drops to 0 immediately; the controller re-enters INIT.
- Masks other than 0 are all writes. Partial masks write only the enabled bytes.

Test Plan:
- Init: assert reset low 3 cycles, release -> sram_ready=0 for 8 cycles then 1; zbt_ce_n=1 and zbt_dq_oe=0 throughout.
- Full write: addr 18'h00005, data 32'hDEADBEEF, mask 4'hF accepted at C -> at C+1 zbt_a=5, ce_n=0, we_n=0, bw_n=0; at C+3 dq_out=DEADBEEF, dq_oe=1; dq_oe=0 at C+2 and C+4.
- Partial write: mask 4'b0101 -> bw_n=4'b1010 at C+1; with a behavioural ZBT model pre-filled with 32'h11111111, a later read of the same address returns 32'h11BE11EF.
- Read latency: read addr 3 at C, model returns 32'h00000002 -> sram_data_out_valid=1 only at C+4 with data 0x2; no other valid pulses.
- Interleaved stream: W0 (addr 0, data 0), W1 (addr 1, data 1), R (addr 1), R (addr 0) on consecutive cycles -> sram_ready never drops; reads return 1 then 0 on consecutive cycles; dq_oe never overlaps a read sample cycle.
- Reset mid-read: two reads issued, reset asserted at C+2 -> no sram_data_out_valid pulse; dq_oe and valid go to 0 asynchronously; after release, ready returns after INIT_CYCLES.

Source files
------------

// File: rtl/sram_zbt_controller.sv
// Pipelined ZBT SRAM controller: one request per cycle, in order, after a fixed init window.
// Latency: accept-to-pins 1 cycle, accept-to-read-data DEV_LATENCY+2 cycles; never back-pressures once running.
module sram_zbt_controller #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 32,
    parameter int DEV_LATENCY = 2,
    parameter int INIT_CYCLES = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sram_addr_valid,
    output logic                      sram_ready,
    input  logic [ADDR_WIDTH-1:0]     sram_addr,
    input  logic [DATA_WIDTH-1:0]     sram_data_in,
    input  logic [DATA_WIDTH/8-1:0]   sram_write_mask,
    output logic [DATA_WIDTH-1:0]     sram_data_out,
    output logic                      sram_data_out_valid,
    output logic [ADDR_WIDTH-1:0]     zbt_a,
    output logic                      zbt_ce_n,
    output logic                      zbt_we_n,
    output logic [DATA_WIDTH/8-1:0]   zbt_bw_n,
    output logic                      zbt_adv_ld_n,
    output logic                      zbt_oe_n,
    output logic [DATA_WIDTH-1:0]     zbt_dq_out,
    output logic                      zbt_dq_oe,
    input  logic [DATA_WIDTH-1:0]     zbt_dq_in
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int CW = $clog2(INIT_CYCLES + 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    logic [CW-1:0]           init_cnt;
    logic                    accept;
    logic                    is_write;

    // Stage k describes the op whose address cycle was k cycles ago.
    logic                    p_vld [0:DEV_LATENCY];
    logic                    p_wr  [0:DEV_LATENCY];
    logic [DATA_WIDTH-1:0]   p_dat [0:DEV_LATENCY-1];

    assign accept       = sram_addr_valid && sram_ready;
    assign is_write     = |sram_write_mask;
    assign zbt_adv_ld_n = 1'b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= INIT;
            init_cnt            <= '0;
            sram_ready          <= 1'b0;
            sram_data_out       <= '0;
            sram_data_out_valid <= 1'b0;
            zbt_a               <= '0;
            zbt_ce_n            <= 1'b1;
            zbt_we_n            <= 1'b1;
            zbt_bw_n            <= '1;
            zbt_oe_n            <= 1'b1;
            zbt_dq_out          <= '0;
            zbt_dq_oe           <= 1'b0;
            for (int i = 0; i <= DEV_LATENCY; i++) begin
                p_vld[i] <= 1'b0;
                p_wr[i]  <= 1'b0;
            end
            for (int i = 0; i < DEV_LATENCY; i++) begin
                p_dat[i] <= '0;
            end
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == CW'(INIT_CYCLES - 1)) begin
                        state      <= RUN;
                        sram_ready <= 1'b1;
                        zbt_oe_n   <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                RUN: begin
                    sram_ready <= 1'b1;
                    zbt_oe_n   <= 1'b0;
                end
                default: state <= INIT;
            endcase

            // Address cycle; zbt_a keeps its last value while idle.
            if (accept) begin
                zbt_a    <= sram_addr;
                zbt_ce_n <= 1'b0;
                zbt_we_n <= !is_write;
                zbt_bw_n <= is_write ? ~sram_write_mask : {MW{1'b1}};
            end else begin
                zbt_ce_n <= 1'b1;
                zbt_we_n <= 1'b1;
                zbt_bw_n <= '1;
            end

            p_vld[0] <= accept;
            p_wr[0]  <= is_write;
            p_dat[0] <= sram_data_in;
            for (int i = 1; i <= DEV_LATENCY; i++) begin
                p_vld[i] <= p_vld[i-1];
                p_wr[i]  <= p_wr[i-1];
            end
            for (int i = 1; i < DEV_LATENCY; i++) begin
                p_dat[i] <= p_dat[i-1];
            end

            // Pad drive lands in the device's data cycle for writes only.
            zbt_dq_oe <= p_vld[DEV_LATENCY-1] && p_wr[DEV_LATENCY-1];
            if (p_vld[DEV_LATENCY-1] && p_wr[DEV_LATENCY-1]) begin
                zbt_dq_out <= p_dat[DEV_LATENCY-1];
            end

            sram_data_out_valid <= p_vld[DEV_LATENCY] && !p_wr[DEV_LATENCY];
            if (p_vld[DEV_LATENCY] && !p_wr[DEV_LATENCY]) begin
                sram_data_out <= zbt_dq_in;
            end
        end
    end
endmodule

// File: tb/tb_sram_zbt_controller.sv
// Randomized scoreboard bench for sram_zbt_controller with a behavioural ZBT device and reference memory.
module tb_sram_zbt_controller;
    localparam int AW  = 18;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam logic [DW-1:0] FILL = 32'h11111111;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          sram_addr_valid = 1'b0;
    logic          sram_ready;
    logic [AW-1:0] sram_addr = '0;
    logic [DW-1:0] sram_data_in = '0;
    logic [3:0]    sram_write_mask = '0;
    logic [DW-1:0] sram_data_out;
    logic          sram_data_out_valid;
    logic [AW-1:0] zbt_a;
    logic          zbt_ce_n, zbt_we_n, zbt_adv_ld_n, zbt_oe_n, zbt_dq_oe;
    logic [3:0]    zbt_bw_n;
    logic [DW-1:0] zbt_dq_out;
    logic [DW-1:0] zbt_dq_in = '0;

    sram_zbt_controller dut (
        .clock(clock), .reset(reset),
        .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready),
        .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_write_mask(sram_write_mask),
        .sram_data_out(sram_data_out), .sram_data_out_valid(sram_data_out_valid),
        .zbt_a(zbt_a), .zbt_ce_n(zbt_ce_n), .zbt_we_n(zbt_we_n), .zbt_bw_n(zbt_bw_n),
        .zbt_adv_ld_n(zbt_adv_ld_n), .zbt_oe_n(zbt_oe_n), .zbt_dq_out(zbt_dq_out),
        .zbt_dq_oe(zbt_dq_oe), .zbt_dq_in(zbt_dq_in)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    bit running = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cy; logic [AW-1:0] a; logic we_n; logic [3:0] bw_n; } pin_t;
    typedef struct { int cy; logic [DW-1:0] d; } dat_t;
    pin_t pin_q[$];
    dat_t wr_q[$];
    dat_t rd_q[$];

    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] dev_mem [int];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [3:0] m);
        logic [DW-1:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] rd_ref(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : FILL;
    endfunction

    function automatic logic [DW-1:0] rd_dev(input int a);
        return dev_mem.exists(a) ? dev_mem[a] : FILL;
    endfunction

    // Behavioural ZBT: address cycle t, data cycle t+LAT.
    logic       dv  [4];
    logic       dwe [4];
    int         da  [4];
    logic [3:0] dbw [4];
    always @(negedge clock) begin
        int p, s;
        if (!reset) begin
            for (int i = 0; i < 4; i++) dv[i] = 1'b0;
        end else begin
            p = (cyc - LAT) & 3;
            if (dv[p]) begin
                if (dwe[p]) begin
                    chk("dev_write_drive", zbt_dq_oe, 1);
                    dev_mem[da[p]] = merge(rd_dev(da[p]), zbt_dq_out, ~dbw[p]);
                end else begin
                    chk("dev_read_no_contention", zbt_dq_oe, 0);
                    zbt_dq_in = rd_dev(da[p]);
                end
                dv[p] = 1'b0;
            end
            if (!zbt_ce_n) begin
                s = cyc & 3;
                dv[s] = 1'b1; dwe[s] = !zbt_we_n; da[s] = int'(zbt_a); dbw[s] = zbt_bw_n;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clock) begin
        pin_t pe;
        dat_t de;
        if (reset) begin
            if (!zbt_ce_n) begin
                if (pin_q.size() == 0) chk("unexpected_ce", 1, 0);
                else begin
                    pe = pin_q.pop_front();
                    chk("addr_cycle", cyc, pe.cy);
                    chk("zbt_a", zbt_a, pe.a);
                    chk("zbt_we_n", zbt_we_n, pe.we_n);
                    chk("zbt_bw_n", zbt_bw_n, pe.bw_n);
                end
            end
            if (zbt_dq_oe) begin
                if (wr_q.size() == 0) chk("unexpected_dq_oe", 1, 0);
                else begin
                    de = wr_q.pop_front();
                    chk("dq_oe_cycle", cyc, de.cy);
                    chk("zbt_dq_out", zbt_dq_out, de.d);
                end
            end
            if (sram_data_out_valid) begin
                if (rd_q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    de = rd_q.pop_front();
                    chk("read_cycle", cyc, de.cy);
                    chk("sram_data_out", sram_data_out, de.d);
                end
            end
            if (running) chk("ready_in_run", sram_ready, 1);
        end
    end

    task automatic issue(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] m, input logic use_exp, input logic [DW-1:0] exp_d);
        @(posedge clock); #1;
        sram_addr_valid = v; sram_addr = a; sram_data_in = d; sram_write_mask = m;
        if (v && sram_ready) begin
            pin_q.push_back('{cyc + 1, a, (m == 4'h0), (m == 4'h0) ? 4'hF : ~m});
            if (m != 4'h0) begin
                ref_mem[int'(a)] = merge(rd_ref(int'(a)), d, m);
                wr_q.push_back('{cyc + 1 + LAT, d});
            end else begin
                rd_q.push_back('{cyc + 2 + LAT, use_exp ? exp_d : rd_ref(int'(a))});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, AW'($urandom), $urandom, 4'($urandom), 1'b0, '0);
    endtask

    task automatic do_reset();
        int n = 0;
        bit bad = 1'b0;
        running = 1'b0;
        reset = 1'b0;
        sram_addr_valid = 1'b0;
        pin_q.delete(); wr_q.delete(); rd_q.delete();
        repeat (3) begin
            @(negedge clock);
            if (sram_data_out_valid || zbt_dq_oe) bad = 1'b1;
        end
        chk("rst_ready", sram_ready, 0);
        chk("rst_valid", sram_data_out_valid, 0);
        chk("rst_data_out", sram_data_out, 0);
        chk("rst_ce_we_oe", {zbt_ce_n, zbt_we_n, zbt_oe_n, zbt_adv_ld_n}, 4'b1110);
        chk("rst_bw_n", zbt_bw_n, 4'hF);
        chk("rst_a", zbt_a, 0);
        chk("rst_dq", {zbt_dq_oe, zbt_dq_out}, 0);
        reset = 1'b1;
        while (!sram_ready && n < 50) begin
            @(posedge clock); #1;
            if (!zbt_ce_n || zbt_dq_oe) bad = 1'b1;
            n++;
        end
        chk("init_cycles", n, 8);
        chk("init_pins_idle", bad, 0);
        chk("run_oe_n", zbt_oe_n, 0);
        running = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m;
        do_reset();

        // Full write, then partial write and readback over the pre-filled device.
        issue(1, 18'h00005, 32'hDEADBEEF, 4'hF, 0, '0);
        idle(2);
        issue(1, 18'h00007, 32'hAABECCEF, 4'b0101, 0, '0);
        idle(1);
        issue(1, 18'h00007, '0, 4'h0, 1, 32'h11BE11EF);
        idle(6);

        // Isolated read latency.
        dev_mem[3] = 32'h00000002;
        ref_mem[3] = 32'h00000002;
        issue(1, 18'h00003, '0, 4'h0, 1, 32'h00000002);
        idle(6);

        // Back-to-back write/write/read/read.
        issue(1, 18'h00000, 32'h0, 4'hF, 0, '0);
        issue(1, 18'h00001, 32'h1, 4'hF, 0, '0);
        issue(1, 18'h00001, '0, 4'h0, 1, 32'h1);
        issue(1, 18'h00000, '0, 4'h0, 1, 32'h0);
        idle(6);

        repeat (400) begin
            m = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            issue($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom, m, 0, '0);
        end
        idle(8);

        // Reset while a write is on the pads and two reads are in flight.
        issue(1, 18'h00009, 32'hCAFEF00D, 4'hF, 0, '0);
        issue(1, 18'h00009, '0, 4'h0, 0, '0);
        issue(1, 18'h00005, '0, 4'h0, 0, '0);
        @(posedge clock); #2;
        sram_addr_valid = 1'b0;
        chk("pre_reset_dq_oe", zbt_dq_oe, 1);
        reset = 1'b0;
        #1;
        chk("async_dq_oe", zbt_dq_oe, 0);
        chk("async_valid", sram_data_out_valid, 0);
        chk("async_ready", sram_ready, 0);
        do_reset();
        ref_mem = dev_mem;

        repeat (60) begin
            m = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            issue($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)), $urandom, m, 0, '0);
        end
        idle(10);

        chk("pin_q_drained", pin_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
